// File: rtl/pipelined_ram.sv
// pipelined_ram: byte-masked read-first RAM with a 2-entry response FIFO
module pipelined_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic [DATA_WIDTH/8-1:0] req_write_mask_in,
    input  logic [31:0]             req_address_in,
    input  logic [DATA_WIDTH-1:0]   req_write_value_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic [DATA_WIDTH-1:0]   resp_read_value_out,
    output logic                    resp_error_out
);
    localparam int LANES       = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = $clog2(LANES);
    localparam int AW          = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] val_q [2];
    logic [1:0]            err_q;
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [31:0]           idx;
    logic                  in_range, push, pop;
    logic [DATA_WIDTH-1:0] rd_word;

    // Ready looks only at occupancy (plus reset, so nothing is taken while held)
    assign idx                 = req_address_in >> OFFSET_BITS;
    assign in_range            = idx < 32'(DEPTH);
    assign rd_word             = in_range ? mem_q[idx[AW-1:0]] : '0;
    assign req_ready_out       = !reset && count_q != 2'd2;
    assign push                = req_valid_in && req_ready_out;
    assign resp_valid_out      = count_q != 2'd0;
    assign pop                 = resp_valid_out && resp_ready_in;
    assign resp_read_value_out = resp_valid_out ? val_q[rd_ptr_q] : '0;
    assign resp_error_out      = resp_valid_out && err_q[rd_ptr_q];

    // Next-state for FIFO pointers and occupancy; push/pop together cancel out
    always_comb begin
        count_d  = count_q + 2'(push) - 2'(pop);
        wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
    end

    // FIFO control state; reset drops every buffered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage: capture the pre-write word into the FIFO, then merge masked lanes
    always_ff @(posedge clk) begin
        if (push) begin
            val_q[wr_ptr_q] <= rd_word;
            err_q[wr_ptr_q] <= !in_range;
        end
        if (push && in_range)
            for (int l = 0; l < LANES; l++)
                if (req_write_mask_in[l])
                    mem_q[idx[AW-1:0]][8*l +: 8] <= req_write_value_in[8*l +: 8];
    end
endmodule

// File: tb/tb_pipelined_ram.sv
// tb_pipelined_ram: directed self-checking bench for pipelined_ram (32-bit, 200 words)
module tb_pipelined_ram;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rdata;
    logic        rerr;
    int          checks = 0;
    int          errors = 0;

    pipelined_ram #(.DATA_WIDTH(32), .DEPTH(200)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid_in        (req_valid),
        .req_ready_out       (req_ready),
        .req_write_mask_in   (mask),
        .req_address_in      (addr),
        .req_write_value_in  (wdata),
        .resp_valid_out      (resp_valid),
        .resp_ready_in       (resp_ready),
        .resp_read_value_out (rdata),
        .resp_error_out      (rerr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        req_valid = 1'b1;
        addr = a;
        mask = m;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mask = 4'h0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        mask = 4'h0;
        addr = 32'h0;
        wdata = 32'h0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_err", {31'b0, rerr}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        // read-first write then read back
        do_req(32'h10, 4'hF, 32'h0000_0000);
        check("w0_valid", {31'b0, resp_valid}, 32'd1);
        check("w0_err", {31'b0, rerr}, 32'd0);
        do_req(32'h10, 4'hF, 32'hDEAD_BEEF);
        check("w1_old", rdata, 32'h0000_0000);
        do_req(32'h10, 4'h0, 32'h0);
        check("r_valid", {31'b0, resp_valid}, 32'd1);
        check("r_data", rdata, 32'hDEAD_BEEF);
        do_req(32'h13, 4'h0, 32'h0);
        check("r_unaligned", rdata, 32'hDEAD_BEEF);
        // partial-lane merge
        do_req(32'h20, 4'hF, 32'h1122_3344);
        check("w2_err", {31'b0, rerr}, 32'd0);
        do_req(32'h22, 4'h5, 32'hAABB_CCDD);
        check("w3_old", rdata, 32'h1122_3344);
        do_req(32'h20, 4'h0, 32'h0);
        check("merge", rdata, 32'h11BB_33DD);
        // out-of-range accesses
        do_req(32'd0, 4'hF, 32'h0102_0304);
        do_req(32'd796, 4'hF, 32'hCAFE_F00D);
        check("w199_err", {31'b0, rerr}, 32'd0);
        do_req(32'd800, 4'hF, 32'hFFFF_FFFF);
        check("oor_err", {31'b0, rerr}, 32'd1);
        check("oor_data", rdata, 32'h0);
        do_req(32'hFFFF_FFFC, 4'hF, 32'hFFFF_FFFF);
        check("oor2_err", {31'b0, rerr}, 32'd1);
        do_req(32'd0, 4'h0, 32'h0);
        check("word0", rdata, 32'h0102_0304);
        check("word0_err", {31'b0, rerr}, 32'd0);
        do_req(32'd796, 4'h0, 32'h0);
        check("word199", rdata, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        check("drain", {31'b0, resp_valid}, 32'd0);
        // backpressure: three back-to-back requests
        resp_ready = 1'b0;
        req_valid = 1'b1;
        addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready1", {31'b0, req_ready}, 32'd1);
        addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready2", {31'b0, req_ready}, 32'd0);
        check("bp_head", rdata, 32'hDEAD_BEEF);
        addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("bp_stall", {31'b0, req_ready}, 32'd0);
        check("bp_stable", rdata, 32'hDEAD_BEEF);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_pop_ready", {31'b0, req_ready}, 32'd1);
        check("bp_head2", rdata, 32'h11BB_33DD);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_full_again", {31'b0, req_ready}, 32'd0);
        check("bp_head2b", rdata, 32'h11BB_33DD);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_head3", rdata, 32'h0102_0304);
        @(posedge clk);
        @(negedge clk);
        check("bp_empty", {31'b0, resp_valid}, 32'd0);
        // full throughput with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            addr = i[0] ? 32'h20 : 32'h10;
            @(posedge clk);
            @(negedge clk);
            check("thru_valid", {31'b0, resp_valid}, 32'd1);
            check("thru_data", rdata, i[0] ? 32'h11BB_33DD : 32'hDEAD_BEEF);
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("thru_end", {31'b0, resp_valid}, 32'd0);
        // reset with two buffered responses
        resp_ready = 1'b0;
        req_valid = 1'b1;
        addr = 32'h10;
        @(posedge clk);
        addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_full", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b1;
        addr = 32'h10;
        mask = 4'hF;
        wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mask = 4'h0;
        reset = 1'b0;
        check("post_rst_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("no_stale", {31'b0, resp_valid}, 32'd0);
        resp_ready = 1'b1;
        do_req(32'h10, 4'h0, 32'h0);
        check("retained", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_ram.md
PIPELINED_RAM -- requirements
Module: pipelined_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width in bits and SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of words and SHALL be at least 2; a non-power-of-two value SHALL be legal.
REQ-003 Derived constant LANES = DATA_WIDTH/8 and OFFSET_BITS = log2(LANES) SHALL be used throughout.
REQ-004 clk  input  1  the block's one clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid_in  input  1  request present.
REQ-007 req_ready_out  output  1  block can accept a request this cycle.
REQ-008 req_write_mask_in  input  LANES  per-byte write enable; bit i covers bits [8i+7:8i].
REQ-009 req_address_in  input  32  byte address.
REQ-010 req_write_value_in  input  DATA_WIDTH  write data.
REQ-011 resp_valid_out  output  1  response present.
REQ-012 resp_ready_in  input  1  consumer accepts the response.
REQ-013 resp_read_value_out  output  DATA_WIDTH  read data.
REQ-014 resp_error_out  output  1  request addressed a word outside DEPTH.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid_in && req_ready_out; a response SHALL be consumed where resp_valid_out && resp_ready_in.
REQ-016 Word index SHALL be req_address_in[31:OFFSET_BITS]; the low OFFSET_BITS address bits SHALL be ignored (no misalignment fault).
REQ-017 On acceptance with index < DEPTH, each lane with mask bit set SHALL be written; lanes with mask bit clear SHALL hold; mask all-zero SHALL be a pure read.
REQ-018 Read data SHALL be read-first: the response SHALL carry the word as it was before that request's own write.
REQ-019 A read accepted the cycle after a write to the same index SHALL return the newly written lanes merged with unwritten old lanes.
REQ-020 On acceptance with index >= DEPTH, memory SHALL be unchanged, and the response SHALL carry resp_read_value_out = 0 and resp_error_out = 1; otherwise resp_error_out = 0.
REQ-021 Responses SHALL be held in a 2-entry in-order FIFO (value + error); an accepted request SHALL push one entry on its acceptance edge.
REQ-022 Latency SHALL be exactly 1 cycle: resp_valid_out SHALL assert the cycle after acceptance when the FIFO was empty.
REQ-023 req_ready_out SHALL be derived only from flops: high when FIFO occupancy < 2, low at occupancy 2, independent of resp_ready_in that cycle.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve ordering.
REQ-025 resp_valid_out SHALL equal (occupancy != 0); resp_read_value_out and resp_error_out SHALL present the head entry and SHALL remain stable while resp_valid_out && !resp_ready_in.
REQ-026 Throughput SHALL be one request per cycle when resp_ready_in is held high.
REQ-027 FIFO pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 or underflow below 0.

Reset
REQ-028 While reset is high: occupancy = 0, pointers = 0, resp_valid_out = 0, resp_error_out = 0, req_ready_out = 0.
REQ-029 The first rising edge with reset low SHALL see req_ready_out = 1; no request SHALL be accepted while reset is high.
REQ-030 Reset asserted mid-operation SHALL discard all buffered responses; memory contents SHALL NOT be reset and SHALL retain prior writes.

Verification
REQ-031 DATA_WIDTH=32: write 0xDEADBEEF to 0x10 mask 0xF, then read 0x10 -> write response returns old word, read response 0xDEADBEEF one cycle after acceptance.
REQ-032 Write 0x11223344 mask 0xF to 0x20, then 0xAABBCCDD mask 0x5 to 0x22 -> subsequent read of 0x20 returns 0x11BB33DD.
REQ-033 resp_ready_in low, three back-to-back requests -> two accepted, req_ready_out low at occupancy 2, third accepted the cycle after first pop; responses in order.
REQ-034 DEPTH=200, write mask 0xF to byte address 800 -> resp_error_out=1, value 0; read of word 0 and word 199 unchanged.
REQ-035 resp_ready_in high, 16 consecutive reads -> 16 responses on 16 consecutive cycles, no bubbles.
REQ-036 Reset pulsed with 2 responses buffered -> resp_valid_out=0 immediately, no stale response after release; earlier writes still readable.
